// File: rtl/snake_tile_arbiter_if.sv
// Signal bundle between the tile arbiter, the VGA timing generator,
// the game-logic writer, the tile RAM and the display output stage.
interface snake_tile_arbiter_if;
  logic [9:0]  h_count;
  logic [9:0]  v_count;
  logic        wr_req;
  logic [5:0]  wr_x;
  logic [4:0]  wr_y;
  logic [11:0] wr_data;
  logic        wr_ack;
  logic [10:0] ram_addr;
  logic        ram_we;
  logic [11:0] ram_wdata;
  logic [11:0] ram_rdata;
  logic [11:0] rbg;

  modport slave (
    input  h_count, v_count, wr_req, wr_x, wr_y, wr_data, ram_rdata,
    output wr_ack, ram_addr, ram_we, ram_wdata, rbg
  );

  modport master (
    output h_count, v_count, wr_req, wr_x, wr_y, wr_data, ram_rdata,
    input  wr_ack, ram_addr, ram_we, ram_wdata, rbg
  );
endinterface

// File: rtl/snake_tile_arbiter.sv
// Shares the single-port tile RAM between display fetches (always win)
// and game-logic writes (fill idle cycles); drives the per-pixel colour.
module snake_tile_arbiter #(
  parameter int TILE_COLS = 40,
  parameter int TILE_ROWS = 30
) (
  input  logic                 clk25,
  input  logic                 rst,
  snake_tile_arbiter_if.slave  bus
);

  localparam logic [9:0] LAST_FETCH_H = 10'((TILE_COLS - 2) * 16 + 13);
  localparam logic [9:0] VIS_LINES    = 10'(TILE_ROWS * 16);
  localparam logic [9:0] BLANK_H      = 10'(TILE_COLS * 16 - 1);
  localparam logic [9:0] PREFETCH_H   = 10'd797;
  localparam logic [9:0] V_LAST       = 10'd524;

  function automatic logic [10:0] tile_addr(input logic [4:0] row, input logic [5:0] col);
    return 11'(row) * 11'(TILE_COLS) + 11'(col);
  endfunction

  logic        wr_ack_q,     wr_ack_d;
  logic        ram_we_q,     ram_we_d;
  logic [10:0] ram_addr_q,   ram_addr_d;
  logic [11:0] ram_wdata_q,  ram_wdata_d;
  logic [11:0] rbg_q,        rbg_d;
  logic        fetch_addr_q, fetch_addr_d;
  logic        fetch_data_q, fetch_data_d;

  logic [9:0]  v_next;
  logic        fetch_cur;
  logic        fetch_nxt;
  logic        fetch_dec;
  logic [10:0] fetch_addr;
  logic        wr_in_range;
  logic        wr_grant;

  always_comb begin
    v_next      = (bus.v_count == V_LAST) ? 10'd0 : bus.v_count + 10'd1;
    fetch_cur   = (bus.h_count[3:0] == 4'd13) && (bus.h_count <= LAST_FETCH_H) &&
                  (bus.v_count < VIS_LINES);
    // column 0 of the next line is fetched during h-blank of this one
    fetch_nxt   = (bus.h_count == PREFETCH_H) && (v_next < VIS_LINES);
    fetch_dec   = fetch_cur || fetch_nxt;
    fetch_addr  = fetch_nxt ? tile_addr(v_next[8:4], 6'd0)
                            : tile_addr(bus.v_count[8:4], bus.h_count[9:4] + 6'd1);
    wr_in_range = (bus.wr_x < 6'(TILE_COLS)) && (bus.wr_y < 5'(TILE_ROWS));
    wr_grant    = !fetch_dec && bus.wr_req && !wr_ack_q;
  end

  always_comb begin
    wr_ack_d     = 1'b0;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    rbg_d        = rbg_q;
    fetch_addr_d = fetch_dec;
    fetch_data_d = fetch_addr_q;

    if (fetch_dec) begin
      ram_addr_d = fetch_addr;
    end else if (wr_grant) begin
      wr_ack_d = 1'b1;
      if (wr_in_range) begin
        ram_we_d    = 1'b1;
        ram_addr_d  = tile_addr(bus.wr_y, bus.wr_x);
        ram_wdata_d = bus.wr_data;
      end
    end

    if (fetch_data_q) rbg_d = bus.ram_rdata;
    if (bus.h_count == BLANK_H) rbg_d = 12'h000;
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      wr_ack_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      rbg_q        <= '0;
      fetch_addr_q <= 1'b0;
      fetch_data_q <= 1'b0;
    end else begin
      wr_ack_q     <= wr_ack_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      rbg_q        <= rbg_d;
      fetch_addr_q <= fetch_addr_d;
      fetch_data_q <= fetch_data_d;
    end
  end

  assign bus.wr_ack    = wr_ack_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.rbg       = rbg_q;

endmodule

// File: tb/tb_snake_tile_arbiter.sv
// Bench for snake_tile_arbiter: drives the scan counters and a game writer,
// models the tile RAM, and scores every cycle against a pixel/tile-level model.
module tb_snake_tile_arbiter;
  logic clk25 = 1'b0;
  logic rst   = 1'b1;
  always #20 clk25 = ~clk25;

  snake_tile_arbiter_if bus();
  snake_tile_arbiter #(.TILE_COLS(40), .TILE_ROWS(30)) dut (.clk25(clk25), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  bit chk_en   = 1'b0;
  bit auto_req = 1'b0;
  bit auto_oor = 1'b0;

  // tile RAM (synchronous read) plus a preload port used only by the bench
  logic [11:0] mem [0:2047];
  logic        pl_en = 1'b0;
  logic [10:0] pl_addr = '0;
  logic [11:0] pl_data = '0;
  always @(posedge clk25) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  // reference model: tile contents, and timed rbg changes by absolute cycle
  typedef struct { longint due; logic [11:0] val; } ev_t;
  ev_t         evq[$];
  logic [11:0] exp_mem [0:2047];
  longint      cyc = 0;
  logic        nx_ack = 1'b0, nx_we = 1'b0;
  logic [10:0] nx_addr = '0;
  logic [11:0] nx_wdata = '0, nx_rbg = '0;
  bit          addr_unk = 1'b0;

  function automatic bit fetch_at(input int h, input int v, output int addr);
    int nv;
    addr = 0;
    if ((h % 16) == 13 && h <= 621 && v < 480) begin
      addr = (v / 16) * 40 + (h / 16) + 1;
      return 1'b1;
    end
    if (h == 797) begin
      nv = (v == 524) ? 0 : v + 1;
      if (nv < 480) begin
        addr = (nv / 16) * 40;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  int  sb_fa;
  bit  sb_f, sb_g, sb_inr;
  ev_t sb_keep[$];
  always @(negedge clk25) begin
    cyc = cyc + 1;
    if (chk_en) begin
      total++;
      if (bus.wr_ack !== nx_ack) begin bad++; $display("FAIL sb_wr_ack cyc=%0d got=%b exp=%b", cyc, bus.wr_ack, nx_ack); end
      total++;
      if (bus.ram_we !== nx_we) begin bad++; $display("FAIL sb_ram_we cyc=%0d got=%b exp=%b", cyc, bus.ram_we, nx_we); end
      if (!addr_unk) begin
        total++;
        if (bus.ram_addr !== nx_addr) begin bad++; $display("FAIL sb_ram_addr cyc=%0d got=%0d exp=%0d", cyc, bus.ram_addr, nx_addr); end
      end
      if (nx_we) begin
        total++;
        if (bus.ram_wdata !== nx_wdata) begin bad++; $display("FAIL sb_ram_wdata cyc=%0d got=%h exp=%h", cyc, bus.ram_wdata, nx_wdata); end
      end
      total++;
      if (bus.rbg !== nx_rbg) begin bad++; $display("FAIL sb_rbg cyc=%0d h=%0d v=%0d got=%h exp=%h", cyc, bus.h_count, bus.v_count, bus.rbg, nx_rbg); end
    end
    if (rst) begin
      nx_ack = 0; nx_we = 0; nx_addr = 0; nx_wdata = 0; nx_rbg = 0; addr_unk = 0;
      evq.delete();
    end else begin
      sb_f   = fetch_at(int'(bus.h_count), int'(bus.v_count), sb_fa);
      sb_g   = !sb_f && bus.wr_req && !nx_ack;
      sb_inr = (bus.wr_x < 40) && (bus.wr_y < 30);
      nx_ack = sb_g;
      nx_we  = sb_g && sb_inr;
      if (sb_f) begin
        nx_addr = 11'(sb_fa); addr_unk = 0;
        evq.push_back('{cyc + 3, exp_mem[sb_fa]});
      end else if (sb_g && sb_inr) begin
        nx_addr  = 11'(int'(bus.wr_y) * 40 + int'(bus.wr_x));
        nx_wdata = bus.wr_data;
        addr_unk = 0;
        exp_mem[int'(bus.wr_y) * 40 + int'(bus.wr_x)] = bus.wr_data;
      end else if (sb_g) begin
        addr_unk = 1;
      end
      if (bus.h_count == 10'd639) evq.push_back('{cyc + 1, 12'h000});
      sb_keep.delete();
      foreach (evq[i]) begin
        if (evq[i].due == cyc + 1) nx_rbg = evq[i].val;
        else if (evq[i].due > cyc + 1) sb_keep.push_back(evq[i]);
      end
      evq = sb_keep;
    end
  end

  task automatic new_req(input bit allow_oor);
    if (allow_oor && $urandom_range(0, 7) == 0) begin
      bus.wr_x = 6'($urandom_range(0, 63));
      bus.wr_y = 5'($urandom_range(0, 31));
    end else begin
      bus.wr_x = 6'($urandom_range(0, 39));
      bus.wr_y = 5'($urandom_range(0, 29));
    end
    bus.wr_data = 12'($urandom_range(0, 4095));
  endtask

  task automatic step();
    @(posedge clk25); #1;
    if (bus.h_count == 10'd799) begin
      bus.h_count = 10'd0;
      bus.v_count = (bus.v_count == 10'd524) ? 10'd0 : bus.v_count + 10'd1;
    end else begin
      bus.h_count = bus.h_count + 10'd1;
    end
    if (auto_req && bus.wr_ack === 1'b1) new_req(auto_oor);
  endtask

  task automatic set_pos(input int v, input int h);
    bus.v_count = 10'(v);
    bus.h_count = 10'(h);
  endtask

  task automatic preload(input int a, input logic [11:0] d);
    pl_addr = 11'(a); pl_data = d; pl_en = 1'b1;
    exp_mem[a] = d;
    step();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (5) step();
    set_pos(100, 300);
    bus.wr_x = 6'd3; bus.wr_y = 5'd4; bus.wr_data = 12'hABC; bus.wr_req = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({bus.wr_ack, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.rbg} !== 37'd0) begin
        bad++;
        $display("FAIL reset_outputs i=%0d got ack=%b we=%b addr=%0d wdata=%h rbg=%h exp all 0",
                 i, bus.wr_ack, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.rbg);
      end
    end
    rst = 1'b0;
    step();
    total++;
    if (bus.wr_ack !== 1'b1 || bus.ram_we !== 1'b1 || bus.ram_addr !== 11'd163 || bus.ram_wdata !== 12'hABC) begin
      bad++;
      $display("FAIL reset_first_write got ack=%b we=%b addr=%0d wdata=%h exp 1 1 163 abc",
               bus.wr_ack, bus.ram_we, bus.ram_addr, bus.ram_wdata);
    end
    bus.wr_req = 1'b0;
    step();
    total++;
    if (bus.wr_ack !== 1'b0) begin bad++; $display("FAIL reset_ack_drop got=%b exp=0", bus.wr_ack); end
  endtask

  task automatic test_scanout();
    preload(0, 12'hF00);
    preload(1, 12'h0F0);
    set_pos(524, 797);
    for (int i = 0; i < 720; i++) begin
      step();
      if (bus.v_count == 10'd524 && bus.h_count == 10'd798) begin
        total++;
        if (bus.ram_addr !== 11'd0 || bus.ram_we !== 1'b0) begin
          bad++; $display("FAIL scan_addr0 got addr=%0d we=%b exp 0 0", bus.ram_addr, bus.ram_we);
        end
      end
      if (bus.v_count == 10'd0 && bus.h_count == 10'd14) begin
        total++;
        if (bus.ram_addr !== 11'd1) begin bad++; $display("FAIL scan_addr1 got=%0d exp=1", bus.ram_addr); end
      end
      if (bus.v_count == 10'd0) begin
        if (bus.h_count < 10'd16) begin
          total++;
          if (bus.rbg !== 12'hF00) begin bad++; $display("FAIL scan_tile0 h=%0d got=%h exp=f00", bus.h_count, bus.rbg); end
        end else if (bus.h_count < 10'd32) begin
          total++;
          if (bus.rbg !== 12'h0F0) begin bad++; $display("FAIL scan_tile1 h=%0d got=%h exp=0f0", bus.h_count, bus.rbg); end
        end else if (bus.h_count >= 10'd640) begin
          total++;
          if (bus.rbg !== 12'h000) begin bad++; $display("FAIL scan_blank h=%0d got=%h exp=000", bus.h_count, bus.rbg); end
        end
      end
    end
  endtask

  task automatic test_write_visible();
    set_pos(200, 100);
    bus.wr_x = 6'd5; bus.wr_y = 5'd3; bus.wr_data = 12'h0FF; bus.wr_req = 1'b1;
    step();
    total++;
    if (bus.ram_addr !== 11'd125 || bus.ram_we !== 1'b1 || bus.wr_ack !== 1'b1 || bus.ram_wdata !== 12'h0FF) begin
      bad++;
      $display("FAIL vis_write got addr=%0d we=%b ack=%b wdata=%h exp 125 1 1 0ff",
               bus.ram_addr, bus.ram_we, bus.wr_ack, bus.ram_wdata);
    end
    bus.wr_req = 1'b0;
    step();
    set_pos(48, 0);
    for (int i = 0; i < 16 * 800; i++) begin
      step();
      if (bus.v_count >= 10'd48 && bus.v_count <= 10'd63 && bus.h_count >= 10'd80 && bus.h_count <= 10'd95) begin
        total++;
        if (bus.rbg !== 12'h0FF) begin
          bad++; $display("FAIL vis_pixel h=%0d v=%0d got=%h exp=0ff", bus.h_count, bus.v_count, bus.rbg);
        end
      end
    end
  endtask

  task automatic test_collision();
    logic [11:0] d;
    preload(1, 12'h0F0);
    set_pos(0, 10);
    repeat (3) step();
    d = 12'($urandom_range(0, 4095));
    bus.wr_x = 6'd7; bus.wr_y = 5'd2; bus.wr_data = d; bus.wr_req = 1'b1;
    step();
    total++;
    if (bus.ram_addr !== 11'd1 || bus.ram_we !== 1'b0 || bus.wr_ack !== 1'b0) begin
      bad++; $display("FAIL coll_fetch got addr=%0d we=%b ack=%b exp 1 0 0", bus.ram_addr, bus.ram_we, bus.wr_ack);
    end
    step();
    total++;
    if (bus.ram_addr !== 11'd87 || bus.ram_we !== 1'b1 || bus.wr_ack !== 1'b1 || bus.ram_wdata !== d) begin
      bad++;
      $display("FAIL coll_write got addr=%0d we=%b ack=%b wdata=%h exp 87 1 1 %h",
               bus.ram_addr, bus.ram_we, bus.wr_ack, bus.ram_wdata, d);
    end
    bus.wr_req = 1'b0;
    step();
    total++;
    if (bus.rbg !== 12'h0F0) begin bad++; $display("FAIL coll_rbg got=%h exp=0f0", bus.rbg); end
  endtask

  task automatic test_out_of_range();
    set_pos(300, 2);
    bus.wr_x = 6'd40; bus.wr_y = 5'd0; bus.wr_data = 12'h123; bus.wr_req = 1'b1;
    step();
    total++;
    if (bus.wr_ack !== 1'b1 || bus.ram_we !== 1'b0) begin
      bad++; $display("FAIL oor_x got ack=%b we=%b exp 1 0", bus.wr_ack, bus.ram_we);
    end
    bus.wr_req = 1'b0;
    step();
    bus.wr_x = 6'd0; bus.wr_y = 5'd30; bus.wr_req = 1'b1;
    step();
    total++;
    if (bus.wr_ack !== 1'b1 || bus.ram_we !== 1'b0) begin
      bad++; $display("FAIL oor_y got ack=%b we=%b exp 1 0", bus.wr_ack, bus.ram_we);
    end
    bus.wr_req = 1'b0;
    step();
    total++;
    if (bus.wr_ack !== 1'b0 || bus.ram_we !== 1'b0) begin
      bad++; $display("FAIL oor_idle got ack=%b we=%b exp 0 0", bus.wr_ack, bus.ram_we);
    end
  endtask

  task automatic test_back_to_back();
    int  dummy, acks;
    bit  have_last, slip;
    longint last, k;
    have_last = 0; slip = 0; last = 0; acks = 0;
    set_pos(100, 0);
    new_req(1'b0);
    bus.wr_req = 1'b1;
    auto_req = 1'b1; auto_oor = 1'b0;
    for (k = 1; k <= 400; k++) begin
      step();
      if (have_last && k == last + 1) slip = fetch_at(int'(bus.h_count), int'(bus.v_count), dummy);
      if (bus.wr_ack === 1'b1) begin
        acks++;
        if (have_last) begin
          total++;
          if (k - last != (slip ? 3 : 2)) begin
            bad++; $display("FAIL b2b_gap k=%0d got=%0d exp=%0d", k, k - last, slip ? 3 : 2);
          end
        end
        have_last = 1; last = k;
      end
    end
    total++;
    if (acks < 180) begin bad++; $display("FAIL b2b_count got=%0d exp>=180", acks); end
    auto_req = 1'b0;
    bus.wr_req = 1'b0;
    step();
  endtask

  task automatic test_random();
    bit prev_ack;
    prev_ack = 0;
    set_pos($urandom_range(0, 470), $urandom_range(0, 799));
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      step();
      total++;
      if (bus.wr_ack === 1'b1 && prev_ack) begin bad++; $display("FAIL rand_ack_twice i=%0d got=11 exp not both", i); end
      prev_ack = (bus.wr_ack === 1'b1);
      if (bus.wr_ack === 1'b1) begin
        bus.wr_req = 1'($urandom_range(0, 1));
        if (bus.wr_req) new_req(1'b1);
      end else if (!bus.wr_req && $urandom_range(0, 3) == 0) begin
        new_req(1'b1);
        bus.wr_req = 1'b1;
      end
    end
    rst = 1'b0;
    bus.wr_req = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    bus.h_count = '0; bus.v_count = '0;
    bus.wr_req = 1'b0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_data = '0;
    rst = 1'b1;
    for (int a = 1200; a < 2048; a++) exp_mem[a] = 12'h000;
    for (int a = 0; a < 1200; a++) preload(a, 12'((a * 37 + 5) & 12'hFFF));
    step();
    chk_en = 1'b1;
    test_reset();
    test_scanout();
    test_write_visible();
    test_collision();
    test_out_of_range();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
